binarize_adaptive: RTL and testbench

//  Upstream stage of Dilation: streaming gray->binary converter whose threshold tracks the frame mean.

---
 rtl/binarize_adaptive.sv | 200 ++++++++++++++++++++
 tb/tb_binarize_adaptive.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/binarize_adaptive.sv
// Streaming gray->binary converter whose threshold follows the previous frame's mean.
// Optional feature: define BINARIZE_ADAPT_CLAMP_EN to clamp the new mean to [THRESH_MIN, THRESH_MAX].
module binarize_adaptive #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 464,
    parameter int THRESH       = 128,
    parameter int THRESH_MIN   = 16,
    parameter int THRESH_MAX   = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gray_valid,
    input  logic [7:0] gray,
    input  logic       adapt_en,
    output logic       bin_valid,
    output logic [7:0] bin_out,
    output logic [7:0] thresh_cur,
    output logic       thresh_upd,
    output logic       frame_end
);
    localparam int N     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int SUM_W = 8 + $clog2(N + 1);
    localparam int CNT_W = $clog2(N);
    localparam int REM_W = CNT_W + 1;
    localparam int DC_W  = $clog2(SUM_W);

    localparam logic [CNT_W-1:0] LAST_PIX    = CNT_W'(N - 1);
    localparam logic [REM_W-1:0] DIVISOR     = REM_W'(N);
    localparam logic [DC_W-1:0]  LAST_STEP   = DC_W'(SUM_W - 1);
    localparam logic [7:0]       THRESH_INIT = 8'(THRESH);

    if (N < 64 || THRESH_MIN > THRESH_MAX) begin : g_cfg_check
        $error("binarize_adaptive: N must be >= 64 and THRESH_MIN <= THRESH_MAX");
    end

`ifdef BINARIZE_ADAPT_CLAMP_EN
    function automatic logic [7:0] limit_thresh(input logic [7:0] q);
        if (q < 8'(THRESH_MIN)) begin
            return 8'(THRESH_MIN);
        end else if (q > 8'(THRESH_MAX)) begin
            return 8'(THRESH_MAX);
        end else begin
            return q;
        end
    endfunction
`else
    function automatic logic [7:0] limit_thresh(input logic [7:0] q);
        return q;
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  pix_cnt_r;
    logic [SUM_W-1:0]  acc_r;
    logic [SUM_W-1:0]  quo_r;
    logic [REM_W-1:0]  rem_r;
    logic [DC_W-1:0]   div_cnt_r;
    logic [7:0]        thresh_next_r;
    logic              pending_r;
    logic [7:0]        thresh_cur_r;
    logic [7:0]        bin_out_r;
    logic              bin_valid_r;
    logic              thresh_upd_r;
    logic              frame_end_r;

    logic [7:0]        eff_thresh_s;
    logic              commit_s;
    logic [REM_W-1:0]  rem_shift_s;
    logic [REM_W-1:0]  rem_new_s;
    logic              q_bit_s;

    // Threshold selection: only the first pixel of a frame may switch the threshold
    always_comb begin
        eff_thresh_s = thresh_cur_r;
        commit_s     = 1'b0;
        if (gray_valid && (pix_cnt_r == '0)) begin
            if (!adapt_en) begin
                eff_thresh_s = THRESH_INIT;
                commit_s     = 1'b1;
            end else if (pending_r) begin
                eff_thresh_s = thresh_next_r;
                commit_s     = 1'b1;
            end else begin
                eff_thresh_s = thresh_cur_r;
            end
        end else begin
            eff_thresh_s = thresh_cur_r;
        end
    end

    // One restoring-divide step; the quotient bit shifts into quo_r as the dividend shifts out
    always_comb begin
        rem_shift_s = {rem_r[REM_W-2:0], quo_r[SUM_W-1]};
        q_bit_s     = 1'b0;
        rem_new_s   = rem_shift_s;
        if (rem_shift_s >= DIVISOR) begin
            q_bit_s   = 1'b1;
            rem_new_s = rem_shift_s - DIVISOR;
        end else begin
            q_bit_s   = 1'b0;
            rem_new_s = rem_shift_s;
        end
    end

    // Divider FSM next state; the divide starts once the frame-end pulse is out
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (frame_end_r) begin
                    state_s = DIV;
                end else begin
                    state_s = IDLE;
                end
            end
            DIV: begin
                if (div_cnt_r == LAST_STEP) begin
                    state_s = DONE;
                end else begin
                    state_s = DIV;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pixel path, frame accumulation, divide datapath and threshold bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_r     <= '0;
            acc_r         <= '0;
            quo_r         <= '0;
            rem_r         <= '0;
            div_cnt_r     <= '0;
            thresh_next_r <= THRESH_INIT;
            pending_r     <= 1'b0;
            thresh_cur_r  <= THRESH_INIT;
            bin_out_r     <= 8'd0;
            bin_valid_r   <= 1'b0;
            thresh_upd_r  <= 1'b0;
            frame_end_r   <= 1'b0;
        end else begin
            bin_valid_r  <= gray_valid;
            frame_end_r  <= 1'b0;
            thresh_upd_r <= (state_r == DONE);

            if (state_r == DIV) begin
                quo_r     <= {quo_r[SUM_W-2:0], q_bit_s};
                rem_r     <= rem_new_s;
                div_cnt_r <= div_cnt_r + DC_W'(1);
            end

            if (gray_valid) begin
                bin_out_r <= (gray >= eff_thresh_s) ? 8'd255 : 8'd0;
                if (commit_s) begin
                    thresh_cur_r <= eff_thresh_s;
                end
                if (pix_cnt_r == LAST_PIX) begin
                    pix_cnt_r   <= '0;
                    acc_r       <= '0;
                    quo_r       <= acc_r + SUM_W'(gray);
                    rem_r       <= '0;
                    div_cnt_r   <= '0;
                    frame_end_r <= 1'b1;
                end else begin
                    pix_cnt_r <= pix_cnt_r + CNT_W'(1);
                    acc_r     <= acc_r + SUM_W'(gray);
                end
            end

            // A DONE coinciding with a frame's first pixel must leave pending set
            if (commit_s) begin
                pending_r <= 1'b0;
            end
            if (state_r == DONE) begin
                pending_r     <= 1'b1;
                thresh_next_r <= limit_thresh(quo_r[7:0]);
            end
        end
    end

    assign bin_valid  = bin_valid_r;
    assign bin_out    = bin_out_r;
    assign thresh_cur = thresh_cur_r;
    assign thresh_upd = thresh_upd_r;
    assign frame_end  = frame_end_r;

endmodule

// File: tb/tb_binarize_adaptive.sv
// Scoreboard bench for binarize_adaptive with an 8x8 frame (N=64, SUM_W=15).
module tb_binarize_adaptive;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gray_valid = 1'b0;
    logic [7:0] gray = 8'd0;
    logic       adapt_en = 1'b1;
    logic       bin_valid;
    logic [7:0] bin_out;
    logic [7:0] thresh_cur;
    logic       thresh_upd;
    logic       frame_end;

    binarize_adaptive #(
        .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .THRESH(128), .THRESH_MIN(16), .THRESH_MAX(240)
    ) dut (
        .clk(clk), .rst(rst), .gray_valid(gray_valid), .gray(gray), .adapt_en(adapt_en),
        .bin_valid(bin_valid), .bin_out(bin_out), .thresh_cur(thresh_cur),
        .thresh_upd(thresh_upd), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

`ifdef BINARIZE_ADAPT_CLAMP_EN
    localparam logic [7:0] ZERO_MEAN_THR = 8'd16;
    localparam logic [7:0] LOW_MEAN_THR  = 8'd16;
`else
    localparam logic [7:0] ZERO_MEAN_THR = 8'd0;
    localparam logic [7:0] LOW_MEAN_THR  = 8'd15;
`endif

    typedef struct packed {
        logic [7:0] bin;
        logic       fe;
        logic [7:0] thr;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         upd_timer = -1;
    logic [7:0] exp_last = 8'd0;
    logic       mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            gray_valid = 1'b0;
        end
    endtask

    // kind 0: all a; 1: alternate a/b; 2: first half a, second half b
    task automatic send_frame(input int kind, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] thr, input int npix);
        exp_t e;
        logic [7:0] g;
        for (int i = 0; i < npix; i++) begin
            if (kind == 0) g = a;
            else if (kind == 1) g = (i % 2 == 0) ? a : b;
            else g = (i < 32) ? a : b;
            @(negedge clk);
            gray_valid = 1'b1;
            gray = g;
            e.bin = (g >= thr) ? 8'd255 : 8'd0;
            e.fe  = (i == 63);
            e.thr = thr;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        gray_valid = 1'b0;
        exp_last = 8'd0;
        upd_timer = -1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_bin_valid", bin_valid, 0);
        chk("rst_bin_out", bin_out, 0);
        chk("rst_thresh_cur", thresh_cur, 128);
        chk("rst_thresh_upd", thresh_upd, 0);
        chk("rst_frame_end", frame_end, 0);
        mon_en = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every bin_valid and tracks the thresh_upd delay
    initial begin
        exp_t e;
        logic exp_upd;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                exp_upd = 1'b0;
                if (upd_timer > 0) begin
                    upd_timer--;
                    if (upd_timer == 0) begin
                        exp_upd = 1'b1;
                        upd_timer = -1;
                    end
                end
                chk("thresh_upd", thresh_upd, exp_upd);
                if (bin_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bin_out", bin_out, e.bin);
                        chk("frame_end", frame_end, e.fe);
                        chk("thresh_cur", thresh_cur, e.thr);
                        exp_last = e.bin;
                        if (e.fe) upd_timer = 17;
                    end
                end else begin
                    chk("bin_out_hold", bin_out, exp_last);
                    chk("frame_end_idle", frame_end, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        adapt_en = 1'b1;
        do_reset();
        // frame of 200s at the reset threshold, then mean 200 applies
        send_frame(0, 8'd200, 8'd200, 8'd128, 64);
        gap(25);
        send_frame(1, 8'd199, 8'd200, 8'd200, 64);   // mean 199
        gap(25);
        send_frame(2, 8'd0, 8'd100, 8'd199, 64);     // mean 50
        gap(25);
        send_frame(1, 8'd50, 8'd49, 8'd50, 64);      // mean 49
        gap(25);
        // back-to-back: second frame starts before the divide completes
        do_reset();
        send_frame(0, 8'd200, 8'd200, 8'd128, 64);
        send_frame(0, 8'd60, 8'd60, 8'd128, 64);     // mean 60 overwrites 200
        gap(25);
        send_frame(1, 8'd60, 8'd59, 8'd60, 64);      // mean 59
        gap(25);
        // adaptation disabled: threshold pinned, update still pulses
        adapt_en = 1'b0;
        send_frame(0, 8'd200, 8'd200, 8'd128, 64);
        gap(25);
        send_frame(0, 8'd200, 8'd200, 8'd128, 64);   // pending mean 200
        gap(25);
        adapt_en = 1'b1;
        send_frame(0, 8'd0, 8'd0, 8'd200, 64);       // mean 0
        gap(25);
        send_frame(1, 8'd15, 8'd16, ZERO_MEAN_THR, 64);
        gap(25);
        // mid-frame reset discards the partial frame
        send_frame(0, 8'd100, 8'd100, LOW_MEAN_THR, 20);
        do_reset();
        send_frame(1, 8'd128, 8'd127, 8'd128, 64);
        gap(30);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
